// File: rtl/dac_interp_fc01.sv
// rtl/dac_interp_fc01.sv - sample FIFO, linear interpolator and dither source feeding the sigma-delta DAC
//
// Accepts 16-bit unsigned samples (midscale 16'h8000) over a valid/ready
// handshake and buffers them in a small FIFO. Between consecutive samples it
// produces a linear ramp, spending 2^OSR_LOG2 clocks per sample. A new word is
// presented on din every clock.
//
// Optional feature macro: DAC_INTERP_NOISE_EN
//   defined   - 16-bit Galois LFSR drives the 4-bit dither word
//   undefined - no LFSR is built and noise is held at 4'h0
//
// Parameters:
//   OSR_LOG2     log2 of clocks per input sample (1..8)
//   FIFO_DEPTH   input FIFO entries (power of two, 2..16)
//
// Ports:
//   clk           system clock, all logic on the rising edge
//   rst_sd        synchronous reset, active high
//   s_valid       upstream sample valid
//   s_ready       FIFO has room; depends only on the registered count
//   s_data        unsigned input sample
//   clr_underrun  clears the sticky underrun flag (a same-cycle set wins)
//   din           interpolated word to the modulator, registered
//   noise         dither word to the modulator, registered
//   underrun      sticky: FIFO was empty at a sample boundary after the first sample
module dac_interp_fc01 #(
  parameter int OSR_LOG2   = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_sd,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  input  logic        clr_underrun,
  output logic [15:0] din,
  output logic [3:0]  noise,
  output logic        underrun
);

  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = AW + 1;
  localparam int ACC_W = 16 + OSR_LOG2;
  localparam logic [15:0] MIDSCALE = 16'h8000;

  // ---------------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------------
  logic [15:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [CW-1:0]       count;
  logic                push;
  logic                pop;
  logic                empty;
  logic                boundary;
  logic [15:0]         head;

  // Interpolator state. The previous sample is not stored separately: it is
  // loaded into acc at each boundary and the ramp is built on top of it.
  logic [OSR_LOG2-1:0] phase;
  logic [15:0]         b_q;
  logic signed [16:0]  delta;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    delta_ext;

  logic                armed;

  assign empty    = (count == '0);
  assign s_ready  = (count < CW'(FIFO_DEPTH));
  assign push     = s_valid && s_ready;
  assign boundary = (phase == {OSR_LOG2{1'b1}});
  assign pop      = boundary && !empty;
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst_sd) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Linear interpolator
  // ---------------------------------------------------------------------------
  // The signed size cast sign-extends delta to the accumulator width, so
  // negative steps wrap the unsigned accumulator downward.
  assign delta_ext = ACC_W'(delta);

  always_ff @(posedge clk) begin
    if (rst_sd) begin
      phase <= '0;
      b_q   <= MIDSCALE;
      delta <= '0;
      acc   <= {MIDSCALE, {OSR_LOG2{1'b0}}};
    end else begin
      phase <= phase + 1'b1;
      if (boundary) begin
        // Restart exactly on the old target so truncation error never
        // accumulates from one segment to the next.
        acc <= {b_q, {OSR_LOG2{1'b0}}};
        if (pop) begin
          b_q   <= head;
          delta <= $signed({1'b0, head}) - $signed({1'b0, b_q});
        end else begin
          delta <= '0;
        end
      end else begin
        acc <= acc + delta_ext;
      end
    end
  end

  // Truncating the fraction gives floor(A + phase*(B-A)/2^OSR_LOG2), which
  // always lies between A and B, so no clamp is needed.
  assign din = acc[ACC_W-1:OSR_LOG2];

  // ---------------------------------------------------------------------------
  // Underrun detection
  // ---------------------------------------------------------------------------
  // Arming stops the idle period after reset from being reported as underrun.
  always_ff @(posedge clk) begin
    if (rst_sd) begin
      armed    <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (push) begin
        armed <= 1'b1;
      end
      if (boundary && empty && armed) begin
        underrun <= 1'b1;
      end else if (clr_underrun) begin
        underrun <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Dither source
  // ---------------------------------------------------------------------------
`ifdef DAC_INTERP_NOISE_EN
  logic [15:0] lfsr;

  // Right-shift Galois form, taps 16'hB400, maximal period 65535.
  always_ff @(posedge clk) begin
    if (rst_sd) begin
      lfsr <= 16'hACE1;
    end else if (lfsr[0]) begin
      lfsr <= (lfsr >> 1) ^ 16'hB400;
    end else begin
      lfsr <= lfsr >> 1;
    end
  end

  assign noise = lfsr[3:0];
`else
  assign noise = 4'h0;
`endif

endmodule

// File: tb/tb_dac_interp_fc01.sv
// tb/tb_dac_interp_fc01.sv - self-checking bench for dac_interp_fc01 with a cycle-tagged din scoreboard
module tb_dac_interp_fc01;

  localparam int OSR = 2;
  localparam int DEPTH = 4;
  localparam int SPAN = 1 << OSR;

  logic        clk = 1'b0;
  logic        rst_sd = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = 16'h0000;
  logic        clr_underrun = 1'b0;
  logic [15:0] din;
  logic [3:0]  noise;
  logic        underrun;

  always #5 clk = ~clk;

  dac_interp_fc01 #(
    .OSR_LOG2   (OSR),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_sd       (rst_sd),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .clr_underrun (clr_underrun),
    .din          (din),
    .noise        (noise),
    .underrun     (underrun)
  );

  typedef struct {
    int          c;
    logic [15:0] v;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_total = 0;

  // cyc = number of rising edges since reset was released.
  int          cyc = 0;
  logic [15:0] lfsr_m;

  always @(posedge clk) begin
    if (rst_sd) begin
      cyc    <= 0;
      lfsr_m <= 16'hACE1;
    end else begin
      cyc    <= cyc + 1;
      lfsr_m <= lfsr_m[0] ? ((lfsr_m >> 1) ^ 16'hB400) : (lfsr_m >> 1);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer and per-cycle dither check, 1 time unit after the edge.
  always @(posedge clk) begin
    logic [3:0] exp_noise;
    #1;
`ifdef DAC_INTERP_NOISE_EN
    exp_noise = lfsr_m[3:0];
`else
    exp_noise = 4'h0;
`endif
    check($sformatf("noise@%0d", cyc), {28'h0, noise}, {28'h0, exp_noise});
    if (!rst_sd) begin
      while (q.size() > 0 && q[0].c <= cyc) begin
        if (q[0].c < cyc) begin
          check($sformatf("din_stale@%0d", q[0].c), 32'(cyc), 32'(q[0].c));
        end else begin
          check($sformatf("din@%0d", cyc), {16'h0, din}, {16'h0, q[0].v});
        end
        void'(q.pop_front());
      end
    end
  end

  task automatic push_const(input int c0, input int c1, input logic [15:0] v);
    for (int c = c0; c <= c1; c++) q.push_back('{c, v});
  endtask

  // Expected ramp: floor(a + p*(b-a)/2^OSR) for p = 0..n-1, starting at cycle c0.
  task automatic push_ramp(input int c0, input int a, input int b, input int n);
    int d;
    d = b - a;
    for (int p = 0; p < n; p++) q.push_back('{c0 + p, 16'(a + ((p * d) >>> OSR))});
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [15:0] d, output int acc_c);
    int guard;
    guard   = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (s_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    acc_c = (guard >= 50) ? -1 : cyc + 1;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int k);
    int guard;
    guard = 0;
    while (cyc < k && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (cyc < k) check("wait_cyc_timeout", 32'(cyc), 32'(k));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int a;
    int acc_cyc[5];
    logic [15:0] smp[5];
    smp = '{16'h1000, 16'hF000, 16'h0100, 16'h7FFF, 16'hABCD};

    // Reset held for two clocks
    repeat (2) @(negedge clk);
    check("rst_din", {16'h0, din}, 32'h8000);
    check("rst_s_ready", {31'h0, s_ready}, 32'h1);
    check("rst_underrun", {31'h0, underrun}, 32'h0);
    rst_sd = 1'b0;

    // Up-ramp 8000 -> 9000, then the FIFO runs dry
    push_const(1, 3, 16'h8000);
    push_ramp(4, 32'h8000, 32'h9000, SPAN);
    push_const(8, 15, 16'h9000);
    send(16'h9000, a);
    check("accept_9000", 32'(a), 32'd1);
`ifdef DAC_INTERP_NOISE_EN
    check("noise_c1", {28'h0, noise}, 32'h0);
    wait_cyc(2);
    check("noise_c2", {28'h0, noise}, 32'h8);
    wait_cyc(3);
    check("noise_c3", {28'h0, noise}, 32'hC);
`endif
    wait_cyc(7);
    check("underrun_before_empty_boundary", {31'h0, underrun}, 32'h0);
    wait_cyc(8);
    check("underrun_after_empty_boundary", {31'h0, underrun}, 32'h1);

    // Clear coinciding with an empty boundary loses to the set
    wait_cyc(11);
    clr_underrun = 1'b1;
    wait_cyc(12);
    clr_underrun = 1'b0;
    check("clear_at_boundary", {31'h0, underrun}, 32'h1);
    clr_underrun = 1'b1;
    wait_cyc(13);
    clr_underrun = 1'b0;
    check("clear_off_boundary", {31'h0, underrun}, 32'h0);

    // Large down-ramp to 0004, settle, then truncating ramp 0004 -> 0000
    push_ramp(16, 32'h9000, 32'h0004, SPAN);
    push_const(20, 23, 16'h0004);
    push_ramp(24, 32'h0004, 32'h0000, SPAN);
    push_const(28, 35, 16'h0000);
    send(16'h0004, a);
    check("accept_0004", 32'(a), 32'd14);
    wait_cyc(16);
    check("no_underrun_when_fed", {31'h0, underrun}, 32'h0);
    wait_cyc(20);
    check("underrun_after_settle", {31'h0, underrun}, 32'h1);
    send(16'h0000, a);
    check("accept_0000", 32'(a), 32'd21);

    // Fill the FIFO: five back-to-back samples from an empty boundary
    push_ramp(36, 0, int'(smp[0]), SPAN);
    for (int i = 1; i < 5; i++) push_ramp(36 + SPAN * i, int'(smp[i-1]), int'(smp[i]), SPAN);
    push_const(56, 59, smp[4]);
    wait_cyc(31);
    for (int i = 0; i < 4; i++) send(smp[i], acc_cyc[i]);
    check("s_ready_low_when_full", {31'h0, s_ready}, 32'h0);
    send(smp[4], acc_cyc[4]);
    for (int i = 0; i < 5; i++) check($sformatf("accept_full_%0d", i), 32'(acc_cyc[i]), 32'(32 + i + (i == 4 ? 1 : 0)));
    wait_cyc(60);
    check("underrun_after_full_drain", {31'h0, underrun}, 32'h1);
    check("scoreboard_drained_1", 32'(q.size()), 32'd0);

    // Reset in the middle of an 8000 -> 9000 ramp with a sample still queued
    rst_sd = 1'b1;
    @(negedge clk);
    rst_sd = 1'b0;
    push_const(1, 3, 16'h8000);
    push_ramp(4, 32'h8000, 32'h9000, 3);
    send(16'h9000, a);
    check("accept_ramp2", 32'(a), 32'd1);
    send(16'h5555, a);
    check("accept_queued", 32'(a), 32'd2);
    wait_cyc(6);
    rst_sd = 1'b1;
    @(negedge clk);
    check("midramp_rst_din", {16'h0, din}, 32'h8000);
    check("midramp_rst_s_ready", {31'h0, s_ready}, 32'h1);
    check("midramp_rst_underrun", {31'h0, underrun}, 32'h0);
    rst_sd = 1'b0;
    push_const(1, 9, 16'h8000);
    wait_cyc(9);
    check("post_rst_underrun", {31'h0, underrun}, 32'h0);
    check("post_rst_s_ready", {31'h0, s_ready}, 32'h1);
    check("scoreboard_drained_2", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
